unibus_npr_arbiter: RTL and testbench

- Shares the single Unibus non-processor-request (NPR) master path among NREQ on-chip DMA engines, such as the switch/light console DMA and disk controllers.
- Owns the NPR/NPG/SACK/BBSY handshake and the grant-chain passthrough, then hands bus mastership to exactly one requester at a time, chosen round-robin.
- The winning requester drives A/C/D/MSYN itself; this block only sequences bus acquisition and release.

---
 rtl/unibus_npr_arbiter.sv | 177 +++++++++++++++++
 tb/tb_unibus_npr_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/unibus_npr_arbiter.sv
// unibus_npr_arbiter: round-robin sequencer for the Unibus NPR master path (Rev 1.0).
// It owns the NPR/NPG/SACK/BBSY handshake and grants the bus to one internal DMA engine at a time.
`default_nettype none

module unibus_npr_arbiter #(
  parameter int NREQ   = 4,
  parameter int SETTLE = 4,
  parameter int TMO    = 1023
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] nak,
  input  logic            init_in_h,
  input  logic            hltgr_in_l,
  input  logic            npg_in_l,
  input  logic            bbsy_in_h,
  input  logic            ssyn_in_h,
  output logic            npr_out_h,
  output logic            npg_out_l,
  output logic            sack_out_h,
  output logic            bbsy_out_h,
  output logic [2:0]      curowner
);

  localparam int CW = $clog2(TMO + 1);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_SETTLE  = 3'd2,
    S_WAITBUS = 3'd3,
    S_OWN     = 3'd4
  } state_t;

  state_t          state, state_n;
  logic [2:0]      sel, sel_n, rr, rr_n, curowner_n, pick_idx, sel_inc;
  logic [CW-1:0]   cnt, cnt_n;
  logic [SW-1:0]   scnt, scnt_n;
  logic            npr_n, sack_n, bbsy_n, found, sel_req, grant_cond;
  logic [NREQ-1:0] grant_n, nak_n, sel_oh;
  int              idx;

  // Never pass a grant downstream while we are requesting it ourselves.
  assign npg_out_l  = npr_out_h ? 1'b1 : npg_in_l;
  assign sel_oh     = {{(NREQ-1){1'b0}}, 1'b1} << sel;
  assign sel_req    = |(req & sel_oh);
  assign grant_cond = ~hltgr_in_l | (npr_out_h & ~npg_in_l);
  assign sel_inc    = (sel == 3'(NREQ - 1)) ? 3'd0 : sel + 3'd1;

  always_comb begin
    pick_idx = rr;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr) + k) % NREQ;
      if (!found && req[idx]) begin
        pick_idx = 3'(idx);
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    state_n    = state;
    sel_n      = sel;
    rr_n       = rr;
    cnt_n      = cnt;
    scnt_n     = scnt;
    npr_n      = npr_out_h;
    sack_n     = sack_out_h;
    bbsy_n     = bbsy_out_h;
    grant_n    = grant;
    nak_n      = '0;
    curowner_n = curowner;
    if (init_in_h) begin
      state_n = S_IDLE;
      npr_n   = 1'b0;
      sack_n  = 1'b0;
      bbsy_n  = 1'b0;
      grant_n = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            sel_n   = pick_idx;
            cnt_n   = '0;
            state_n = S_REQ;
          end
        end
        S_REQ: begin
          // Timeout wins over a requester dropping out in the same cycle.
          if (cnt == CW'(TMO)) begin
            npr_n   = 1'b0;
            nak_n   = sel_oh;
            rr_n    = sel_inc;
            state_n = S_IDLE;
          end else if (!sel_req) begin
            npr_n   = 1'b0;
            state_n = S_IDLE;
          end else begin
            cnt_n = cnt + 1'b1;
            if (!hltgr_in_l || (npr_out_h && !npg_in_l)) begin
              scnt_n  = '0;
              state_n = S_SETTLE;
            end else if (npg_in_l) begin
              npr_n = 1'b1;
            end
          end
        end
        S_SETTLE: begin
          if (cnt != CW'(TMO)) cnt_n = cnt + 1'b1;
          if (!grant_cond) begin
            state_n = S_REQ;
          end else if (scnt == SW'(SETTLE - 1)) begin
            sack_n  = 1'b1;
            npr_n   = 1'b0;
            state_n = S_WAITBUS;
          end else begin
            scnt_n = scnt + 1'b1;
          end
        end
        S_WAITBUS: begin
          if (!bbsy_in_h && !ssyn_in_h) begin
            bbsy_n     = 1'b1;
            sack_n     = 1'b0;
            grant_n    = sel_oh;
            curowner_n = sel;
            state_n    = S_OWN;
          end
        end
        S_OWN: begin
          if (!sel_req) begin
            grant_n = '0;
            bbsy_n  = 1'b0;
            rr_n    = sel_inc;
            state_n = S_IDLE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state      <= S_IDLE;
      sel        <= 3'd0;
      rr         <= 3'd0;
      cnt        <= '0;
      scnt       <= '0;
      npr_out_h  <= 1'b0;
      sack_out_h <= 1'b0;
      bbsy_out_h <= 1'b0;
      grant      <= '0;
      nak        <= '0;
      curowner   <= 3'd0;
    end else begin
      state      <= state_n;
      sel        <= sel_n;
      rr         <= rr_n;
      cnt        <= cnt_n;
      scnt       <= scnt_n;
      npr_out_h  <= npr_n;
      sack_out_h <= sack_n;
      bbsy_out_h <= bbsy_n;
      grant      <= grant_n;
      nak        <= nak_n;
      curowner   <= curowner_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_unibus_npr_arbiter.sv
// tb_unibus_npr_arbiter: directed and randomized bus acquisitions checked against a round-robin model.
`default_nettype none

module tb_unibus_npr_arbiter;
  localparam int NREQ   = 4;
  localparam int SETTLE = 4;
  localparam int TMO    = 1023;

  logic            clk = 1'b0;
  logic            rst, init_in, hltgr_l, npg_l, bbsy_in, ssyn_in;
  logic [NREQ-1:0] req, grant, nak;
  logic            npr, npg_out_l, sack, bbsy_out;
  logic [2:0]      curowner;

  int checks   = 0;
  int failures = 0;
  int m_rr     = 0;

  always #5 clk = ~clk;

  unibus_npr_arbiter #(.NREQ(NREQ), .SETTLE(SETTLE), .TMO(TMO)) dut (
    .CLOCK(clk), .RESET(rst), .req(req), .grant(grant), .nak(nak),
    .init_in_h(init_in), .hltgr_in_l(hltgr_l), .npg_in_l(npg_l),
    .bbsy_in_h(bbsy_in), .ssyn_in_h(ssyn_in), .npr_out_h(npr),
    .npg_out_l(npg_out_l), .sack_out_h(sack), .bbsy_out_h(bbsy_out),
    .curowner(curowner)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock, then the bus-level invariants that must hold in every cycle.
  task automatic tick();
    @(negedge clk);
    chk("inv_onehot", 32'($onehot0(grant)), 32'd1);
    chk("inv_bbsy_grant", 32'(bbsy_out), 32'(|grant));
    chk("inv_npr_sack_bbsy", 32'(npr & sack & bbsy_out), 32'd0);
    chk("npg_passthru", 32'(npg_out_l), 32'(npr ? 1'b1 : npg_l));
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_rr + k) % NREQ;
      if (r[i]) return i;
    end
    return 0;
  endfunction

  function automatic logic [NREQ-1:0] oh(input int s);
    logic [NREQ-1:0] one;
    one = 1;
    return one << s;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req = '0; init_in = 1'b0; hltgr_l = 1'b1;
    npg_l = 1'b1; bbsy_in = 1'b0; ssyn_in = 1'b0;
    tick(); tick();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_nak", 32'(nak), 32'd0);
    chk("rst_npr", 32'(npr), 32'd0);
    chk("rst_sack", 32'(sack), 32'd0);
    chk("rst_bbsy", 32'(bbsy_out), 32'd0);
    chk("rst_curowner", 32'(curowner), 32'd0);
    rst  = 1'b0;
    m_rr = 0;
  endtask

  // Drive one acquisition from IDLE to OWN; returns the requester the model expects to win.
  task automatic acquire(input logic [NREQ-1:0] reqv, input bit halted, input int npg_delay,
                         input int glitch, input int busy, input bit cancel_settle, output int sel);
    logic [NREQ-1:0] o;
    sel = model_pick(reqv);
    o   = oh(sel);
    req = reqv;
    hltgr_l = ~halted;
    if (busy > 0) begin
      if ($urandom_range(0, 1) == 1) bbsy_in = 1'b1;
      else ssyn_in = 1'b1;
    end
    tick();
    chk("lat1_npr", 32'(npr), 32'd0);
    chk("pre_grant", 32'(grant), 32'd0);
    if (!halted) begin
      tick();
      chk("lat2_npr", 32'(npr), 32'd1);
      for (int d = 0; d < npg_delay; d++) begin
        tick();
        chk("wait_npg_npr", 32'(npr), 32'd1);
        chk("wait_npg_sack", 32'(sack), 32'd0);
      end
      if (glitch > 0) begin
        npg_l = 1'b0;
        for (int g = 0; g < glitch; g++) begin
          tick();
          chk("glitch_sack", 32'(sack), 32'd0);
        end
        npg_l = 1'b1;
        for (int g = 0; g < 2; g++) begin
          tick();
          chk("post_glitch_sack", 32'(sack), 32'd0);
          chk("post_glitch_npr", 32'(npr), 32'd1);
        end
      end
      npg_l = 1'b0;
      tick();
      chk("npg_seen_sack", 32'(sack), 32'd0);
    end else begin
      tick();
      chk("halt_npr", 32'(npr), 32'd0);
    end
    for (int i = 1; i <= SETTLE; i++) begin
      if (cancel_settle && i == 2) req = '0;
      tick();
      chk("settle_sack", 32'(sack), 32'(i == SETTLE));
      chk("settle_npr", 32'(npr), 32'(!halted && i < SETTLE));
    end
    npg_l = 1'b1;
    for (int b = 0; b < busy; b++) begin
      tick();
      chk("waitbus_grant", 32'(grant), 32'd0);
      chk("waitbus_sack", 32'(sack), 32'd1);
    end
    bbsy_in = 1'b0;
    ssyn_in = 1'b0;
    tick();
    chk("grant", 32'(grant), 32'(o));
    chk("grant_bbsy", 32'(bbsy_out), 32'd1);
    chk("grant_sack", 32'(sack), 32'd0);
    chk("grant_curowner", 32'(curowner), 32'(sel));
    chk("grant_nak", 32'(nak), 32'd0);
    hltgr_l = 1'b1;
    if (cancel_settle) begin
      tick();
      chk("cancel_release", 32'(grant), 32'd0);
      m_rr = (sel + 1) % NREQ;
    end
  endtask

  task automatic release_bus(input int sel, input int hold, input bit keep_others);
    logic [NREQ-1:0] o;
    o = oh(sel);
    for (int h = 0; h < hold; h++) begin
      req = NREQ'($urandom) | o;
      tick();
      chk("own_hold", 32'(grant), 32'(o));
    end
    req = keep_others ? (req & ~o) : '0;
    tick();
    chk("release_grant", 32'(grant), 32'd0);
    chk("release_bbsy", 32'(bbsy_out), 32'd0);
    chk("release_curowner", 32'(curowner), 32'(sel));
    m_rr = (sel + 1) % NREQ;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, s2;
    logic [NREQ-1:0] r, o;

    do_reset();

    acquire(4'b0001, 1'b0, 3, 0, 2, 1'b0, s);
    release_bus(s, 2, 1'b0);

    acquire(4'b0100, 1'b1, 0, 0, 0, 1'b0, s);
    release_bus(s, 1, 1'b0);

    acquire(NREQ'($urandom_range(1, 15)), 1'b0, 1, 2, 1, 1'b0, s);
    release_bus(s, 0, 1'b0);

    // NPG never arrives: nak pulses TMO cycles after NPR rises.
    r = NREQ'($urandom_range(1, 15));
    s = model_pick(r);
    o = oh(s);
    req = r;
    tick();
    chk("tmo_lat1_npr", 32'(npr), 32'd0);
    tick();
    chk("tmo_lat2_npr", 32'(npr), 32'd1);
    for (int i = 1; i <= TMO; i++) begin
      tick();
      chk("tmo_nak", 32'(nak), 32'((i == TMO) ? o : '0));
      chk("tmo_npr", 32'(npr), 32'(i < TMO));
    end
    req = '0;
    tick();
    chk("tmo_nak_single", 32'(nak), 32'd0);
    m_rr = (s + 1) % NREQ;
    acquire(4'b1111, 1'b0, 0, 0, 0, 1'b0, s);
    release_bus(s, 0, 1'b0);

    // Drop out while still in REQ: no nak, pointer unchanged.
    r = NREQ'($urandom_range(1, 15));
    req = r;
    tick();
    tick();
    chk("cancel_req_npr_up", 32'(npr), 32'd1);
    req = '0;
    tick();
    chk("cancel_req_npr", 32'(npr), 32'd0);
    chk("cancel_req_nak", 32'(nak), 32'd0);
    acquire(NREQ'($urandom_range(1, 15)), 1'b0, 0, 0, 0, 1'b0, s);
    release_bus(s, 1, 1'b0);

    acquire(NREQ'($urandom_range(1, 15)), 1'b0, 1, 0, 1, 1'b1, s);

    // INIT while owning: bus dropped, pointer kept, same requester wins again.
    r = NREQ'($urandom_range(1, 15));
    acquire(r, 1'b0, 0, 0, 0, 1'b0, s);
    tick();
    init_in = 1'b1;
    tick();
    chk("init_grant", 32'(grant), 32'd0);
    chk("init_bbsy", 32'(bbsy_out), 32'd0);
    chk("init_npr", 32'(npr), 32'd0);
    chk("init_sack", 32'(sack), 32'd0);
    init_in = 1'b0;
    acquire(r, 1'b0, 0, 0, 0, 1'b0, s2);
    release_bus(s2, 0, 1'b0);

    for (int n = 0; n < 16; n++) begin
      bit h;
      int gl;
      h  = ($urandom_range(0, 3) == 0);
      gl = (!h && $urandom_range(0, 3) == 0) ? $urandom_range(1, SETTLE) : 0;
      acquire(NREQ'($urandom_range(1, 15)), h, $urandom_range(0, 4), gl,
              $urandom_range(0, 3), 1'b0, s);
      release_bus(s, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // All requesters held: strict rotation starting from requester 0 after reset.
    do_reset();
    for (int n = 0; n < 5; n++) begin
      acquire(4'b1111, 1'b0, 0, 0, 0, 1'b0, s);
      release_bus(s, 0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
